// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for uart_xcvr. The parity-only states exist when UART_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BREAK} rx_state_t;
`else
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
`endif

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Payload is zero-extended to 9 bits, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_xcvr_if.sv
`timescale 1ns/1ps
// Bus-side handshake bundle of uart_xcvr: master is the register logic, slave is the transceiver.
interface uart_xcvr_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
// Bit-period down-counter: tick when the count reaches zero, then reload a full period.
// clear reloads a full period, or a half period when half is set. No backpressure.
module uart_bit_timer #(
  parameter int CPB = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic half,
  output logic tick
);
  localparam int W = $clog2(CPB);
  localparam logic [W-1:0] FULL  = W'(CPB - 1);
  localparam logic [W-1:0] HALFP = W'(CPB / 2 - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == '0) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= FULL;
    end else if (clear) begin
      cnt <= half ? HALFP : FULL;
    end else if (cnt == '0) begin
      cnt <= FULL;
    end else begin
      cnt <= cnt - W'(1);
    end
  end
endmodule

// File: rtl/uart_xcvr.sv
`timescale 1ns/1ps
// Full-duplex UART (UART_PARITY_EN adds a parity bit): start bit on tx one cycle after accept, rx_valid ~3 cycles after the stop-bit centre.
// TX backpressures through tx_ready, which is high only while idle; RX has no flow control and overwrites rx_data.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_xcvr_if.slave bus,
  output logic       tx,
  input  logic       rx
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_chk
    $error("uart_xcvr: illegal parameters (CLK_HZ/BAUD >= 4, DATA_BITS 5..9, STOP_BITS 1..2)");
  end

`ifdef UART_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
`endif

  // ---------------- transmitter ----------------
  tx_state_t            tx_st, tx_st_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic [BW-1:0]        tx_bc, tx_bc_n;
  logic                 tx_accept, tx_tick;

  uart_bit_timer #(.CPB(CPB)) u_tx_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tx_accept),
    .half  (1'b0),
    .tick  (tx_tick)
  );

`ifdef UART_PARITY_EN
  logic tx_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tx_par <= 1'b0;
    else if (tx_accept) tx_par <= parity_bit(9'(bus.tx_data), ODD);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st <= T_IDLE;
      tx_sh <= '0;
      tx_bc <= '0;
    end else begin
      tx_st <= tx_st_n;
      tx_sh <= tx_sh_n;
      tx_bc <= tx_bc_n;
    end
  end

  always_comb begin
    tx_st_n      = tx_st;
    tx_sh_n      = tx_sh;
    tx_bc_n      = tx_bc;
    tx_accept    = 1'b0;
    tx           = 1'b1;
    bus.tx_ready = 1'b0;
    bus.tx_done  = 1'b0;
    case (tx_st)
      T_IDLE: begin
        bus.tx_ready = 1'b1;
        if (bus.tx_valid) begin
          tx_accept = 1'b1;
          tx_sh_n   = bus.tx_data;
          tx_st_n   = T_START;
        end
      end
      T_START: begin
        tx = 1'b0;
        if (tx_tick) begin
          tx_bc_n = '0;
          tx_st_n = T_DATA;
        end
      end
      T_DATA: begin
        tx = tx_sh[0];
        if (tx_tick) begin
          tx_sh_n = tx_sh >> 1;
          if (tx_bc == BW'(DATA_BITS - 1)) begin
            tx_bc_n = '0;
`ifdef UART_PARITY_EN
            tx_st_n = T_PAR;
`else
            tx_st_n = T_STOP;
`endif
          end else begin
            tx_bc_n = tx_bc + BW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      T_PAR: begin
        tx = tx_par;
        if (tx_tick) tx_st_n = T_STOP;
      end
`endif
      T_STOP: begin
        if (tx_tick) begin
          if (tx_bc == BW'(STOP_BITS - 1)) begin
            bus.tx_done = 1'b1;
            tx_st_n     = T_IDLE;
          end else begin
            tx_bc_n = tx_bc + BW'(1);
          end
        end
      end
      default: tx_st_n = T_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync;
  logic                 rx_s;
  rx_state_t            rx_st, rx_st_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic [BW-1:0]        rx_bc, rx_bc_n;
  logic                 rx_clear, rx_half, rx_tick, rx_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end
  assign rx_s = rx_sync[1];

  uart_bit_timer #(.CPB(CPB)) u_rx_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rx_clear),
    .half  (rx_half),
    .tick  (rx_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st <= R_IDLE;
      rx_sh <= '0;
      rx_bc <= '0;
    end else begin
      rx_st <= rx_st_n;
      rx_sh <= rx_sh_n;
      rx_bc <= rx_bc_n;
    end
  end

  always_comb begin
    rx_st_n  = rx_st;
    rx_sh_n  = rx_sh;
    rx_bc_n  = rx_bc;
    rx_clear = 1'b0;
    rx_half  = 1'b0;
    rx_load  = 1'b0;
    case (rx_st)
      R_IDLE: begin
        if (!rx_s) begin
          rx_clear = 1'b1;
          rx_half  = 1'b1;
          rx_st_n  = R_START;
        end
      end
      R_START: begin
        rx_bc_n = '0;
        if (rx_tick) rx_st_n = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: begin
        if (rx_tick) begin
          rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_bc == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            rx_st_n = R_PAR;
`else
            rx_st_n = R_STOP;
`endif
          end else begin
            rx_bc_n = rx_bc + BW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      R_PAR: begin
        if (rx_tick) rx_st_n = R_STOP;
      end
`endif
      R_STOP: begin
        if (rx_tick) begin
          rx_load = 1'b1;
          rx_st_n = rx_s ? R_IDLE : R_BREAK;
        end
      end
      R_BREAK: begin
        if (rx_s) rx_st_n = R_IDLE;
      end
      default: rx_st_n = R_IDLE;
    endcase
  end

  // Results land at the stop-bit sample so they are stable when rx_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_valid     <= 1'b0;
      bus.rx_data      <= '0;
      bus.rx_frame_err <= 1'b0;
    end else begin
      bus.rx_valid <= rx_load;
      if (rx_load) begin
        bus.rx_data      <= rx_sh;
        bus.rx_frame_err <= !rx_s;
      end
    end
  end

`ifdef UART_PARITY_EN
  logic rx_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_par            <= 1'b0;
      bus.rx_parity_err <= 1'b0;
    end else begin
      if (rx_st == R_PAR && rx_tick) rx_par <= rx_s;
      if (rx_load) bus.rx_parity_err <= (rx_par != parity_bit(9'(rx_sh), ODD));
    end
  end
`else
  assign bus.rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_xcvr.sv
`timescale 1ns/1ps
// Directed bench for uart_xcvr at 10 clocks per bit; rx is either looped back from tx or driven directly.
module tb_uart_xcvr;
  import uart_pkg::*;

  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam int DB = 7;
  localparam int P  = 1;
`else
  localparam int DB = 8;
  localparam int P  = 0;
`endif
  localparam int F  = 2 + DB + P;
  localparam int FC = F * CPB;

  typedef struct {
    logic [8:0] data;
    bit         inj;
    bit         stop_bad;
    bit         par_flip;
    logic [8:0] exp_data;
    bit         exp_fe;
    bit         exp_pe;
  } vec_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic rx_drv  = 1'b1;
  logic loop_en = 1'b1;
  logic tx;
  logic rx;

  uart_xcvr_if #(.DATA_BITS(DB)) bus ();

  uart_xcvr #(
    .CLK_HZ     (1_000_000),
    .BAUD       (100_000),
    .DATA_BITS  (DB),
    .STOP_BITS  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .tx    (tx),
    .rx    (rx)
  );

  assign rx = loop_en ? tx : rx_drv;
  always #500 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DB-1:0] rx_q[$];
  logic          fe_q[$];
  logic          pe_q[$];
  vec_t          vecs[6];

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_q.push_back(bus.rx_data);
      fe_q.push_back(bus.rx_frame_err);
      pe_q.push_back(bus.rx_parity_err);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DB-1:0] mk(input logic [8:0] v);
    return v[DB-1:0];
  endfunction

  task automatic wait_rx(input int base, output bit got);
    got = 1'b0;
    for (int i = 0; i < 3 * FC; i++) begin
      if (rx_q.size() > base) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_rx(input string name, input int base, input logic [DB-1:0] d,
                          input logic fe, input logic pe);
    bit got;
    wait_rx(base, got);
    check({name, "_valid"}, 32'(got), 1);
    if (got) begin
      check({name, "_data"}, 32'(rx_q[base]), 32'(d));
      check({name, "_frame_err"}, 32'(fe_q[base]), 32'(fe));
      check({name, "_parity_err"}, 32'(pe_q[base]), 32'(pe));
    end
    repeat (2 * CPB) @(negedge clk);
    check({name, "_pulses"}, 32'(rx_q.size() - base), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * FC && bus.tx_ready !== 1'b1; i++) @(negedge clk);
    check("tx_idle_wait", 32'(bus.tx_ready), 1);
    repeat (CPB) @(negedge clk);
  endtask

  // Returns #1 after the accepting clock edge.
  task automatic send_byte(input logic [DB-1:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 2 * FC && bus.tx_ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
  endtask

  task automatic inject(input logic [DB-1:0] d, input bit stop_bad, input bit par_flip);
    logic [11:0] bits;
    int          nb;
    loop_en = 1'b0;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1 + i] = d[i];
    if (P == 1) bits[1 + DB] = (^d) ^ par_flip;
    bits[1 + DB + P] = !stop_bad;
    nb = 2 + DB + P;
    for (int b = 0; b < nb; b++) begin
      @(posedge clk);
      #1 rx_drv = bits[b];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk);
    #1 rx_drv = !stop_bad;
  endtask

  initial begin
    int   base;
    bit   got;
    int   lowcnt, done_n, done_at;
    logic b0, b1, rdy_a, rdy_b, s_stop, s_idle, s_start, r_idle, r_busy;

    vecs[0] = '{9'h03C, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0};
    vecs[1] = '{9'h03C, 1'b1, 1'b1, 1'b0, 9'h03C, 1'b1, 1'b0};
    vecs[2] = '{9'h081, 1'b1, 1'b0, 1'b0, 9'h081, 1'b0, 1'b0};
    vecs[3] = '{9'h0C3, 1'b1, 1'b0, 1'b1, 9'h0C3, 1'b0, (P == 1)};
    vecs[4] = '{9'h055, 1'b0, 1'b0, 1'b0, 9'h055, 1'b0, 1'b0};
    vecs[5] = '{9'h00F, 1'b1, 1'b0, 1'b0, 9'h00F, 1'b0, 1'b0};

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_tx_ready", 32'(bus.tx_ready), 1);
    check("rst_tx_done", 32'(bus.tx_done), 0);
    check("rst_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_rx_frame_err", 32'(bus.rx_frame_err), 0);
    check("rst_rx_parity_err", 32'(bus.rx_parity_err), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Loopback of 0xA5 with cycle-exact TX timing.
    base = rx_q.size();
    send_byte(mk(9'h0A5));
    lowcnt = 0; done_n = 0; done_at = 0;
    b0 = 1'bx; b1 = 1'bx; rdy_a = 1'bx; rdy_b = 1'bx;
    for (int k = 1; k <= FC + 1; k++) begin
      @(negedge clk);
      if (k <= CPB && tx == 1'b0) lowcnt++;
      if (k == CPB + 1) b0 = tx;
      if (k == 2 * CPB + 1) b1 = tx;
      if (bus.tx_done) begin
        done_n++;
        done_at = k;
      end
      if (k == FC) rdy_a = bus.tx_ready;
      if (k == FC + 1) rdy_b = bus.tx_ready;
    end
    check("a5_start_low_cycles", 32'(lowcnt), CPB);
    check("a5_bit0", 32'(b0), 1);
    check("a5_bit1", 32'(b1), 0);
    check("a5_tx_done_pulses", 32'(done_n), 1);
    check("a5_tx_done_cycle", 32'(done_at), FC);
    check("a5_tx_ready_busy", 32'(rdy_a), 0);
    check("a5_tx_ready_back", 32'(rdy_b), 1);
    check_rx("a5", base, mk(9'h0A5), 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with tx_valid held: data change while busy only affects the second frame.
    base = rx_q.size();
    @(negedge clk);
    bus.tx_data  = '0;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus.tx_data = mk(9'h1FF);
    s_stop = 1'bx; s_idle = 1'bx; s_start = 1'bx; r_idle = 1'bx; r_busy = 1'bx;
    for (int k = 1; k <= FC + 2; k++) begin
      @(negedge clk);
      if (k == FC) begin
        s_stop = tx;
        r_busy = bus.tx_ready;
      end
      if (k == FC + 2) s_start = tx;
      if (k == FC + 1) begin
        s_idle = tx;
        r_idle = bus.tx_ready;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
      end
    end
    check("b2b_stop_high", 32'(s_stop), 1);
    check("b2b_ready_busy", 32'(r_busy), 0);
    check("b2b_idle_high", 32'(s_idle), 1);
    check("b2b_idle_ready", 32'(r_idle), 1);
    check("b2b_second_start", 32'(s_start), 0);
    wait_rx(base + 1, got);
    check("b2b_two_valid", 32'(got), 1);
    if (got) begin
      check("b2b_first_data", 32'(rx_q[base]), 32'(mk(9'h000)));
      check("b2b_second_data", 32'(rx_q[base + 1]), 32'(mk(9'h1FF)));
      check("b2b_second_frame_err", 32'(fe_q[base + 1]), 0);
    end
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      base = rx_q.size();
      if (vecs[i].inj) begin
        inject(mk(vecs[i].data), vecs[i].stop_bad, vecs[i].par_flip);
      end else begin
        loop_en = 1'b1;
        send_byte(mk(vecs[i].data));
      end
      check_rx($sformatf("vec%0d", i), base, mk(vecs[i].exp_data), vecs[i].exp_fe, vecs[i].exp_pe);
      if (vecs[i].stop_bad) begin
        repeat (3 * FC) @(negedge clk);
        check($sformatf("vec%0d_break_hold", i), 32'(rx_q.size() - base), 1);
        @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (CPB) @(posedge clk);
      end
      wait_idle();
    end

    // Three-cycle low glitch on an idle line.
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    base    = rx_q.size();
    @(posedge clk);
    #1 rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("glitch_rx_idle", 32'(dut.rx_st), 32'(R_IDLE));
    check("glitch_no_pulse", 32'(rx_q.size() - base), 0);
    inject(mk(9'h096), 1'b0, 1'b0);
    check_rx("post_glitch", base, mk(9'h096), 1'b0, 1'b0);

    // Reset asserted during data bit 3 of a loopback frame.
    wait_idle();
    loop_en = 1'b1;
    base    = rx_q.size();
    send_byte(mk(9'h053));
    repeat (4 * CPB + 4) @(posedge clk);
    #200;
    check("pre_rst_bit3_low", 32'(tx), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 1);
    check("rst_mid_tx_ready", 32'(bus.tx_ready), 1);
    check("rst_mid_rx_valid", 32'(bus.rx_valid), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * FC) @(negedge clk);
    check("rst_mid_no_pulse", 32'(rx_q.size() - base), 0);
    send_byte(mk(9'h06B));
    check_rx("post_rst", base, mk(9'h06B), 1'b0, 1'b0);

`ifdef UART_PARITY_EN
    // 0x55 over 7 bits has four ones, so the even-parity bit is 0.
    wait_idle();
    base = rx_q.size();
    send_byte(mk(9'h055));
    repeat ((1 + DB) * CPB + 4) @(posedge clk);
    #200;
    check("par55_tx_parity_bit", 32'(tx), 0);
    check_rx("par55", base, mk(9'h055), 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #40_000_000;
    $display("FAIL watchdog: simulation exceeded 40000 cycles, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
